cpu_bus_responder: RTL and testbench

Responder end of the 6502 CPU memory bus. It decodes every CPU address and serves it from one of four targets: 2 KB internal work RAM, the PPU register window, the PRG-ROM port, or open bus. It returns registered read data to the CPU and executes writes. It also contains the $4014 OAM DMA engine, which stalls the CPU through cpu_rdy while it copies one 256-byte page into PPU register 4.

---
 rtl/cpu_bus_responder_if.sv | 19 +
 rtl/cpu_bus_responder.sv | 173 +++++++++++++++++
 tb/tb_cpu_bus_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus of the 6502 memory responder: address, write strobe/data,
// registered read data and the ready/stall line.
interface cpu_bus_responder_if;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;

  modport master (
    output cpu_addr, cpu_we, cpu_wdata,
    input  cpu_rdata, cpu_rdy
  );

  modport slave (
    input  cpu_addr, cpu_we, cpu_wdata,
    output cpu_rdata, cpu_rdy
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// 6502 bus responder: work RAM, PPU window, PRG-ROM port, open bus, and the
// $4014 OAM DMA engine (present only when CPU_BUS_OAMDMA_EN is defined).
module cpu_bus_responder #(
  parameter int RAM_AW = 11,
  parameter int PRG_AW = 15
) (
  input  logic                clk,
  input  logic                rst,
  cpu_bus_responder_if.slave  cpu,
  output logic                ppu_cs,
  output logic [2:0]          ppu_reg,
  output logic                ppu_we,
  output logic [7:0]          ppu_wdata,
  input  logic [7:0]          ppu_rdata,
  output logic [PRG_AW-1:0]   prg_addr,
  input  logic [7:0]          prg_rdata,
  output logic                dma_active
);

  logic [7:0]        ram_r [0:(1<<RAM_AW)-1];
  logic [7:0]        cpu_rdata_r;
  logic [15:0]       a_s;
  logic              dma_idle_s;
  logic              dma_rd_s;
  logic              dma_wr_s;
  logic [7:0]        dma_buf_s;
  logic              access_s;
  logic              sel_ram_s;
  logic              sel_ppu_s;
  logic              sel_prg_s;
  logic [7:0]        rdata_s;
  logic              ram_we_s;
  logic              ppu_cs_s;
  logic [2:0]        ppu_reg_s;
  logic              ppu_we_s;
  logic [7:0]        ppu_wdata_s;
  logic [PRG_AW-1:0] prg_addr_s;

`ifdef CPU_BUS_OAMDMA_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_RD, ST_WR} dma_state_e;

  dma_state_e state_r;
  dma_state_e state_s;
  logic [7:0] page_r;
  logic [7:0] idx_r;
  logic [7:0] dma_buf_r;
  logic       trig_s;

  assign trig_s     = (state_r == ST_IDLE) && cpu.cpu_we && (cpu.cpu_addr == 16'h4014);
  assign dma_idle_s = (state_r == ST_IDLE);
  assign dma_rd_s   = (state_r == ST_RD);
  assign dma_wr_s   = (state_r == ST_WR);
  assign dma_buf_s  = dma_buf_r;
  assign a_s        = dma_idle_s ? cpu.cpu_addr : {page_r, idx_r};

  // DMA state register plus page/index/buffer datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      page_r    <= 8'h00;
      idx_r     <= 8'h00;
      dma_buf_r <= 8'h00;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (trig_s) begin
            page_r <= cpu.cpu_wdata;
            idx_r  <= 8'h00;
          end
        end
        ST_RD:   dma_buf_r <= rdata_s;
        ST_WR:   idx_r     <= idx_r + 8'h01;
        default: ;
      endcase
    end
  end

  // DMA next-state: one align cycle, then 256 read/write pairs
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) state_s = ST_ALIGN;
        else        state_s = ST_IDLE;
      end
      ST_ALIGN: state_s = ST_RD;
      ST_RD:    state_s = ST_WR;
      ST_WR: begin
        if (idx_r == 8'hFF) state_s = ST_IDLE;
        else                state_s = ST_RD;
      end
      default:  state_s = ST_IDLE;
    endcase
  end
`else
  assign dma_idle_s = 1'b1;
  assign dma_rd_s   = 1'b0;
  assign dma_wr_s   = 1'b0;
  assign dma_buf_s  = 8'h00;
  assign a_s        = cpu.cpu_addr;
`endif

  // ALIGN and WR cycles present no source address to the map
  assign access_s  = dma_idle_s | dma_rd_s;
  assign sel_ram_s = (a_s[15:13] == 3'b000);
  assign sel_ppu_s = (a_s[15:13] == 3'b001);
  assign sel_prg_s = a_s[15];
  assign ram_we_s  = dma_idle_s && cpu.cpu_we && sel_ram_s;

  // Read-data mux; anything unmapped re-presents the held open-bus byte
  always_comb begin
    rdata_s = cpu_rdata_r;
    if (sel_ram_s)      rdata_s = ram_r[a_s[RAM_AW-1:0]];
    else if (sel_ppu_s) rdata_s = ppu_rdata;
    else if (sel_prg_s) rdata_s = prg_rdata;
    else                rdata_s = cpu_rdata_r;
  end

  // Work RAM array, deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we_s) ram_r[a_s[RAM_AW-1:0]] <= cpu.cpu_wdata;
  end

  // Registered CPU read data, updated only by mapped CPU reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_r <= 8'h00;
    end else if (dma_idle_s && !cpu.cpu_we && (sel_ram_s || sel_ppu_s || sel_prg_s)) begin
      cpu_rdata_r <= rdata_s;
    end
  end

  // PPU and PRG side strobes, all held at zero while reset is asserted
  always_comb begin
    ppu_cs_s    = 1'b0;
    ppu_reg_s   = 3'd0;
    ppu_we_s    = 1'b0;
    ppu_wdata_s = 8'h00;
    prg_addr_s  = {PRG_AW{1'b0}};
    if (!rst) begin
      ppu_cs_s = 1'b0;
    end else if (dma_wr_s) begin
      ppu_cs_s    = 1'b1;
      ppu_we_s    = 1'b1;
      ppu_reg_s   = 3'd4;
      ppu_wdata_s = dma_buf_s;
    end else if (access_s && sel_ppu_s) begin
      ppu_cs_s  = 1'b1;
      ppu_reg_s = a_s[2:0];
      if (dma_idle_s && cpu.cpu_we) begin
        ppu_we_s    = 1'b1;
        ppu_wdata_s = cpu.cpu_wdata;
      end else begin
        ppu_we_s    = 1'b0;
      end
    end else if (access_s && sel_prg_s) begin
      prg_addr_s = a_s[PRG_AW-1:0];
    end else begin
      ppu_cs_s = 1'b0;
    end
  end

  assign cpu.cpu_rdata = cpu_rdata_r;
  assign cpu.cpu_rdy   = dma_idle_s;
  assign dma_active    = !dma_idle_s;
  assign ppu_cs        = ppu_cs_s;
  assign ppu_reg       = ppu_reg_s;
  assign ppu_we        = ppu_we_s;
  assign ppu_wdata     = ppu_wdata_s;
  assign prg_addr      = prg_addr_s;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: vector table for the address map,
// hand sequences for OAM DMA (when CPU_BUS_OAMDMA_EN is defined) and reset.
module tb_cpu_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        ppu_cs;
  logic [2:0]  ppu_reg;
  logic        ppu_we;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata;
  logic        dma_active;
  int          n_checks = 0;
  int          n_err = 0;

  cpu_bus_responder_if bus();

  cpu_bus_responder #(.RAM_AW(11), .PRG_AW(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (bus),
    .ppu_cs     (ppu_cs),
    .ppu_reg    (ppu_reg),
    .ppu_we     (ppu_we),
    .ppu_wdata  (ppu_wdata),
    .ppu_rdata  (ppu_rdata),
    .prg_addr   (prg_addr),
    .prg_rdata  (prg_rdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  ppu_d;
    logic [7:0]  prg_d;
    logic        cs;
    logic        pwe;
    logic [2:0]  preg;
    logic [7:0]  pwd;
    logic [14:0] paddr;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_cycle(input logic [15:0] addr, input logic we, input logic [7:0] wd);
    @(negedge clk);
    bus.cpu_addr  = addr;
    bus.cpu_we    = we;
    bus.cpu_wdata = wd;
    @(posedge clk);
    #1;
  endtask

`ifdef CPU_BUS_OAMDMA_EN
  task automatic run_dma(input logic [7:0] page, input logic [7:0] hold);
    int busy = 0;
    int nwr = 0;
    int nrdcs = 0;
    int bad_act = 0;
    int bad_hold = 0;
    logic [7:0] expd;
    logic [7:0] n8;
    @(negedge clk);
    bus.cpu_addr  = 16'h4014;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = page;
    @(negedge clk);
    // CPU keeps writing $0000 during the stall; must be ignored
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'hFF;
    for (int c = 0; c < 700; c++) begin
      if (bus.cpu_rdy) break;
      busy++;
      if (dma_active !== 1'b1) bad_act++;
      if (bus.cpu_rdata !== hold) bad_hold++;
      if (ppu_cs && !ppu_we) nrdcs++;
      if (ppu_we) begin
        n8 = nwr[7:0];
        expd = (page == 8'h02) ? (n8 ^ 8'h5A) : 8'h6E;
        chk("dma_wdata", {8'h00, ppu_wdata}, {8'h00, expd});
        chk("dma_reg", {13'd0, ppu_reg}, 16'd4);
        nwr++;
      end
      @(negedge clk);
    end
    bus.cpu_we = 1'b0;
    chk("dma_rdy_low_cycles", busy[15:0], 16'd513);
    chk("dma_write_count", nwr[15:0], 16'd256);
    chk("dma_active_during", bad_act[15:0], 16'd0);
    chk("dma_rdata_hold", bad_hold[15:0], 16'd0);
    chk("dma_src_ppu_cs", nrdcs[15:0], (page == 8'h20) ? 16'd256 : 16'd0);
    chk("dma_active_after", {15'd0, dma_active}, 16'd0);
  endtask
`endif

  initial begin
    vecs[0]  = '{16'h0005, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'h00};
    vecs[1]  = '{16'h0805, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'hA5};
    vecs[2]  = '{16'h1805, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'hA5};
    vecs[3]  = '{16'h2006, 1'b1, 8'h3F, 8'h00, 8'h00, 1'b1, 1'b1, 3'd6, 8'h3F, 15'h0000, 8'hA5};
    vecs[4]  = '{16'h3FFA, 1'b0, 8'h00, 8'h80, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 15'h0000, 8'h80};
    vecs[5]  = '{16'hFFFC, 1'b0, 8'h00, 8'h00, 8'h4C, 1'b0, 1'b0, 3'd0, 8'h00, 15'h7FFC, 8'h4C};
    vecs[6]  = '{16'h0005, 1'b0, 8'h00, 8'h00, 8'h4C, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'hA5};
    vecs[7]  = '{16'h8000, 1'b0, 8'h00, 8'h00, 8'h4C, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'h4C};
    vecs[8]  = '{16'h5000, 1'b0, 8'h00, 8'h77, 8'h99, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'h4C};
    vecs[9]  = '{16'h4014, 1'b0, 8'h00, 8'h77, 8'h99, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'h4C};
    vecs[10] = '{16'h8123, 1'b1, 8'h11, 8'h00, 8'h99, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0123, 8'h4C};
    vecs[11] = '{16'h1FFF, 1'b1, 8'hC3, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'h4C};
    vecs[12] = '{16'h07FF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'hC3};
    vecs[13] = '{16'h5000, 1'b1, 8'hEE, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 15'h0000, 8'hC3};
    vecs[14] = '{16'h2FFF, 1'b0, 8'h00, 8'h12, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 15'h0000, 8'h12};

    // Reset state, with inputs that would otherwise light the PPU strobes
    rst = 1'b0;
    bus.cpu_addr  = 16'h2001;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = 8'h55;
    ppu_rdata = 8'h00;
    prg_rdata = 8'h00;
    #22;
    chk("rst_rdata", {8'h00, bus.cpu_rdata}, 16'h0000);
    chk("rst_rdy", {15'd0, bus.cpu_rdy}, 16'd1);
    chk("rst_dma_active", {15'd0, dma_active}, 16'd0);
    chk("rst_ppu_cs", {15'd0, ppu_cs}, 16'd0);
    chk("rst_ppu_we", {15'd0, ppu_we}, 16'd0);
    bus.cpu_addr = 16'hFFFF;
    bus.cpu_we   = 1'b0;
    #1;
    chk("rst_prg_addr", {1'b0, prg_addr}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Address-map vectors
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.cpu_addr  = vecs[i].addr;
      bus.cpu_we    = vecs[i].we;
      bus.cpu_wdata = vecs[i].wdata;
      ppu_rdata     = vecs[i].ppu_d;
      prg_rdata     = vecs[i].prg_d;
      #1;
      chk($sformatf("v%0d_ppu_cs", i), {15'd0, ppu_cs}, {15'd0, vecs[i].cs});
      chk($sformatf("v%0d_ppu_we", i), {15'd0, ppu_we}, {15'd0, vecs[i].pwe});
      if (vecs[i].cs) chk($sformatf("v%0d_ppu_reg", i), {13'd0, ppu_reg}, {13'd0, vecs[i].preg});
      if (vecs[i].pwe) chk($sformatf("v%0d_ppu_wdata", i), {8'h00, ppu_wdata}, {8'h00, vecs[i].pwd});
      if (vecs[i].addr[15]) chk($sformatf("v%0d_prg_addr", i), {1'b0, prg_addr}, {1'b0, vecs[i].paddr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rdata", i), {8'h00, bus.cpu_rdata}, {8'h00, vecs[i].rdata});
      chk($sformatf("v%0d_rdy", i), {15'd0, bus.cpu_rdy}, 16'd1);
    end
    ppu_rdata = 8'h00;
    prg_rdata = 8'h00;

`ifdef CPU_BUS_OAMDMA_EN
    for (int i = 0; i < 256; i++) begin
      bus_cycle(16'h0200 + 16'(i), 1'b1, 8'(i) ^ 8'h5A);
    end
    bus_cycle(16'h0000, 1'b1, 8'h33);
    bus_cycle(16'h0000, 1'b0, 8'h00);
    chk("pre_dma_read", {8'h00, bus.cpu_rdata}, 16'h0033);
    run_dma(8'h02, 8'h33);
    bus_cycle(16'h0000, 1'b0, 8'h00);
    chk("post_dma_read0", {8'h00, bus.cpu_rdata}, 16'h0033);
    bus_cycle(16'h0210, 1'b0, 8'h00);
    chk("post_dma_read210", {8'h00, bus.cpu_rdata}, 16'h004A);

    // Reset after the 100th PPU write of a DMA
    begin
      int nwr = 0;
      int bad_we = 0;
      @(negedge clk);
      bus.cpu_addr  = 16'h4014;
      bus.cpu_we    = 1'b1;
      bus.cpu_wdata = 8'h02;
      @(negedge clk);
      bus.cpu_addr = 16'h0000;
      bus.cpu_we   = 1'b0;
      for (int c = 0; c < 400; c++) begin
        if (ppu_we) nwr++;
        if (nwr == 100) break;
        @(negedge clk);
      end
      chk("mid_dma_reached_100", nwr[15:0], 16'd100);
      rst = 1'b0;
      #1;
      chk("mid_rst_rdy", {15'd0, bus.cpu_rdy}, 16'd1);
      chk("mid_rst_dma_active", {15'd0, dma_active}, 16'd0);
      chk("mid_rst_ppu_we", {15'd0, ppu_we}, 16'd0);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (ppu_we) bad_we++;
      end
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (ppu_we || !bus.cpu_rdy) bad_we++;
      end
      chk("after_rst_no_ppu_we", bad_we[15:0], 16'd0);
    end
    run_dma(8'h02, 8'h00);
    ppu_rdata = 8'h6E;
    run_dma(8'h20, 8'h00);
    ppu_rdata = 8'h00;
`else
    // Without the DMA engine $4014 is plain unmapped space
    bus_cycle(16'h8000, 1'b0, 8'h00);
    @(negedge clk);
    bus.cpu_addr  = 16'h4014;
    bus.cpu_we    = 1'b1;
    bus.cpu_wdata = 8'h02;
    prg_rdata     = 8'h21;
    #1;
    chk("nodma_ppu_cs", {15'd0, ppu_cs}, 16'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      bus.cpu_we = 1'b0;
      chk($sformatf("nodma_rdy_%0d", c), {15'd0, bus.cpu_rdy}, 16'd1);
      chk($sformatf("nodma_active_%0d", c), {15'd0, dma_active}, 16'd0);
    end
    chk("nodma_4014_open_bus", {8'h00, bus.cpu_rdata}, 16'h0000);
    bus_cycle(16'h8001, 1'b0, 8'h00);
    chk("nodma_prg_read", {8'h00, bus.cpu_rdata}, 16'h0021);
    bus_cycle(16'h4014, 1'b0, 8'h00);
    chk("nodma_4014_read", {8'h00, bus.cpu_rdata}, 16'h0021);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
